// File: rtl/am2940_pkg.sv
// Shared definitions for the am2940 transfer sequencer: opcodes, control-word layout, FSM states.
package am2940_pkg;

  localparam logic [2:0] OP_WR_CTRL = 3'b000;
  localparam logic [2:0] OP_RD_CTRL = 3'b001;
  localparam logic [2:0] OP_RD_WC   = 3'b010;
  localparam logic [2:0] OP_RD_AC   = 3'b011;
  localparam logic [2:0] OP_REINIT  = 3'b100;
  localparam logic [2:0] OP_LD_ADDR = 3'b101;
  localparam logic [2:0] OP_LD_WC   = 3'b110;
  localparam logic [2:0] OP_ENABLE  = 3'b111;

  localparam int CW_MODE_LSB = 0;
  localparam int CW_MODE_W   = 2;
  localparam int CW_DOWN_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CTRL = 3'd1,
    ST_LD_ADDR = 3'd2,
    ST_LD_WC   = 3'd3,
    ST_RUN     = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  function automatic logic [2:0] ctrl_word(input logic down, input logic [CW_MODE_W-1:0] mode);
    logic [2:0] cw;
    cw = '0;
    cw[CW_DOWN_BIT] = down;
    cw[CW_MODE_LSB +: CW_MODE_W] = mode;
    return cw;
  endfunction

endpackage

// File: rtl/am2940_beat_cnt.sv
// Remaining-beat counter plus per-beat ack timeout timer for the am2940 sequencer.
module am2940_beat_cnt #(
  parameter int DW      = 8,
  parameter int ACK_TMO = 15
) (
  input  logic          clk,
  input  logic          rstneg,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          dec,
  input  logic          wait_tick,
  output logic          last,
  output logic          gt1,
  output logic          zero,
  output logic          timeout
);

  localparam int CW = DW + 1;
  localparam int TW = $clog2(ACK_TMO + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TMO);

  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;

  // Timer counts down from ACK_TMO; it expires when it reaches zero without an ack.
  always_ff @(posedge clk or negedge rstneg) begin
    if (!rstneg) begin
      cnt <= '0;
      tmr <= TMO_LOAD;
    end else if (load) begin
      cnt <= (load_val == '0) ? (CW'(1) << DW) : {1'b0, load_val};
      tmr <= TMO_LOAD;
    end else if (dec) begin
      cnt <= cnt - CW'(1);
      tmr <= TMO_LOAD;
    end else if (wait_tick && (tmr != '0)) begin
      tmr <= tmr - TW'(1);
    end
  end

  assign last    = (cnt == CW'(1));
  assign gt1     = (cnt > CW'(1));
  assign zero    = (cnt == '0);
  assign timeout = (tmr == '0);

endmodule

// File: rtl/am2940_dma_seq.sv
// Block-transfer sequencer: programs am2940 over its instruction bus, then steps it once per memory beat.
//   state    | meaning
//   IDLE     | waiting for a request, am2940 parked on RD_CTRL
//   WR_CTRL  | write direction/mode control word
//   LD_ADDR  | load start address
//   LD_WC    | load word count, arm beat counter
//   RUN      | issue memory beats, step am2940 on each ack
//   FINISH   | check am2940 done, report outcome
module am2940_dma_seq
  import am2940_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ACK_TMO = 15
) (
  input  logic          clk,
  input  logic          rstneg,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_addr,
  input  logic [DW-1:0] req_count,
  input  logic [1:0]    req_mode,
  input  logic          req_down,
  input  logic          abort,
  output logic [2:0]    instr,
  output logic [DW-1:0] dma_data,
  output logic          acineg,
  output logic          wcineg,
  input  logic          done,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          busy,
  output logic          xfer_done,
  output logic          xfer_err
);

  state_e        state, next_state;
  logic [DW-1:0] addr_q, count_q;
  logic [1:0]    mode_q;
  logic          down_q;
  logic          accept;
  logic          step, cnt_load, wait_tick;
  logic          cnt_last, cnt_gt1, cnt_zero, ack_tmo;

  assign accept = (state == ST_IDLE) && req_valid;

  always_ff @(posedge clk or negedge rstneg) begin
    if (!rstneg) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      mode_q  <= '0;
      down_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q  <= req_addr;
        count_q <= req_count;
        mode_q  <= req_mode;
        down_q  <= req_down;
      end
    end
  end

  am2940_beat_cnt #(
    .DW      (DW),
    .ACK_TMO (ACK_TMO)
  ) u_beat_cnt (
    .clk       (clk),
    .rstneg    (rstneg),
    .load      (cnt_load),
    .load_val  (count_q),
    .dec       (step),
    .wait_tick (wait_tick),
    .last      (cnt_last),
    .gt1       (cnt_gt1),
    .zero      (cnt_zero),
    .timeout   (ack_tmo)
  );

  always_comb begin
    next_state = state;
    instr      = OP_RD_CTRL;
    dma_data   = '0;
    mem_req    = 1'b0;
    step       = 1'b0;
    cnt_load   = 1'b0;
    wait_tick  = 1'b0;
    xfer_done  = 1'b0;
    xfer_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) next_state = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        instr      = OP_WR_CTRL;
        dma_data   = {{(DW-3){1'b0}}, ctrl_word(down_q, mode_q)};
        next_state = ST_LD_ADDR;
      end
      ST_LD_ADDR: begin
        instr      = OP_LD_ADDR;
        dma_data   = addr_q;
        next_state = ST_LD_WC;
      end
      ST_LD_WC: begin
        instr      = OP_LD_WC;
        dma_data   = count_q;
        cnt_load   = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        instr = OP_ENABLE;
        if (ack_tmo) begin
          xfer_err   = 1'b1;
          next_state = ST_IDLE;
        end else begin
          mem_req = 1'b1;
          // am2940 claiming done while more than one beat remains means the two disagree on length.
          if (done && cnt_gt1) begin
            xfer_err   = 1'b1;
            next_state = ST_IDLE;
          end else if (cnt_zero) begin
            next_state = ST_FINISH;
          end else if (mem_ack) begin
            step = 1'b1;
            if (cnt_last) next_state = ST_FINISH;
          end else begin
            wait_tick = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        if (done) xfer_done = 1'b1;
        else      xfer_err  = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    if (abort && (state != ST_IDLE)) begin
      next_state = ST_IDLE;
      step       = 1'b0;
      cnt_load   = 1'b0;
      wait_tick  = 1'b0;
      xfer_done  = 1'b0;
      xfer_err   = 1'b1;
    end
  end

  // Count enables follow this cycle's ack so am2940 advances on the same edge that retires the beat.
  assign acineg    = ~step;
  assign wcineg    = ~step;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_am2940_dma_seq.sv
// Directed + randomized bench for am2940_dma_seq with a behavioural am2940 and memory responder.
module tb_am2940_dma_seq;

  logic       clk;
  logic       rstneg;
  logic       req_valid, req_ready;
  logic [7:0] req_addr, req_count;
  logic [1:0] req_mode;
  logic       req_down;
  logic       abort;
  logic [2:0] instr;
  logic [7:0] dma_data;
  logic       acineg, wcineg;
  logic       done;
  logic       mem_req, mem_ack;
  logic       busy, xfer_done, xfer_err;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural am2940: control, address and word counters
  logic [2:0] m_ctrl;
  logic [7:0] m_ac;
  logic [8:0] m_wc;
  logic       m_loaded;
  logic       force_done;

  am2940_dma_seq #(.DW(8), .ACK_TMO(15)) dut (
    .clk       (clk),
    .rstneg    (rstneg),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_count (req_count),
    .req_mode  (req_mode),
    .req_down  (req_down),
    .abort     (abort),
    .instr     (instr),
    .dma_data  (dma_data),
    .acineg    (acineg),
    .wcineg    (wcineg),
    .done      (done),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .xfer_done (xfer_done),
    .xfer_err  (xfer_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstneg) begin
    if (!rstneg) begin
      m_ctrl   <= '0;
      m_ac     <= '0;
      m_wc     <= '0;
      m_loaded <= 1'b0;
    end else begin
      case (instr)
        3'b000: m_ctrl <= dma_data[2:0];
        3'b101: m_ac   <= dma_data;
        3'b110: begin
          m_wc     <= (dma_data == 8'd0) ? 9'd256 : {1'b0, dma_data};
          m_loaded <= 1'b1;
        end
        default: ;
      endcase
      if (!acineg) m_ac <= m_ctrl[2] ? m_ac - 8'd1 : m_ac + 8'd1;
      if (!wcineg) m_wc <= m_wc - 9'd1;
    end
  end

  assign done = (m_loaded && (m_wc == 9'd0)) || force_done;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_instr"},     instr, 3'b001);
    chk({pfx, "_dma_data"},  dma_data, 8'h00);
    chk({pfx, "_acineg"},    acineg, 1'b1);
    chk({pfx, "_wcineg"},    wcineg, 1'b1);
    chk({pfx, "_mem_req"},   mem_req, 1'b0);
    chk({pfx, "_req_ready"}, req_ready, 1'b1);
    chk({pfx, "_busy"},      busy, 1'b0);
    chk({pfx, "_xfer_done"}, xfer_done, 1'b0);
    chk({pfx, "_xfer_err"},  xfer_err, 1'b0);
  endtask

  task automatic drive_busy_inputs(input bit poke);
    req_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
    if (poke) begin
      req_addr  = 8'($urandom);
      req_count = 8'($urandom);
      req_mode  = 2'($urandom);
      req_down  = 1'($urandom);
    end
  endtask

  // gap: idle cycles before each ack (-1 random); abort_beat / pdone_beat: beat index at which
  // abort or a premature done is injected (-1 none); no_ack: memory never answers.
  task automatic do_xfer(input logic [7:0] a, input logic [7:0] c, input logic dn,
                         input logic [1:0] md, input int gap, input int abort_beat,
                         input int pdone_beat, input bit no_ack, input bit poke);
    int n, beats, idle_run, steps;
    bit fin, normal, ack, ab;
    logic [7:0] exp_a;
    n = (c == 8'd0) ? 256 : int'(c);
    beats = 0; idle_run = 0; steps = 0; fin = 0; normal = 0;

    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_count = c; req_mode = md; req_down = dn;
    mem_ack = 1'b0; abort = 1'b0; force_done = 1'b0;
    #1;
    chk("accept_ready", req_ready, 1'b1);
    chk("accept_instr", instr, 3'b001);

    @(negedge clk); drive_busy_inputs(poke); #1;
    chk("wr_ctrl_instr", instr, 3'b000);
    chk("wr_ctrl_data", dma_data, {5'b0, dn, md});
    chk("wr_ctrl_busy", busy, 1'b1);
    chk("wr_ctrl_ready", req_ready, 1'b0);

    @(negedge clk); drive_busy_inputs(poke); #1;
    chk("ld_addr_instr", instr, 3'b101);
    chk("ld_addr_data", dma_data, a);
    chk("ld_addr_memreq", mem_req, 1'b0);

    @(negedge clk); drive_busy_inputs(poke); #1;
    chk("ld_wc_instr", instr, 3'b110);
    chk("ld_wc_data", dma_data, c);
    chk("ld_wc_acineg", acineg, 1'b1);

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      drive_busy_inputs(poke);
      if (no_ack)       ack = 1'b0;
      else if (gap < 0) ack = ($urandom_range(0, 2) == 0) || (idle_run >= 13);
      else              ack = (idle_run >= gap);
      ab = (abort_beat >= 0) && (beats == abort_beat);
      force_done = (pdone_beat >= 0) && (beats == pdone_beat);
      abort = ab;
      mem_ack = ack;
      exp_a = dn ? a - 8'(beats) : a + 8'(beats);
      #1;
      chk("run_instr", instr, 3'b111);
      chk("run_ready", req_ready, 1'b0);
      if (!acineg) steps++;
      if (ab) begin
        chk("abort_err", xfer_err, 1'b1);
        chk("abort_acineg", acineg, 1'b1);
        chk("abort_wcineg", wcineg, 1'b1);
        chk("abort_done", xfer_done, 1'b0);
        fin = 1;
      end else if (idle_run == 15) begin
        chk("tmo_memreq", mem_req, 1'b0);
        chk("tmo_err", xfer_err, 1'b1);
        fin = 1;
      end else if (force_done && (n - beats > 1)) begin
        chk("pdone_err", xfer_err, 1'b1);
        chk("pdone_acineg", acineg, 1'b1);
        fin = 1;
      end else begin
        chk("run_memreq", mem_req, 1'b1);
        chk("run_err", xfer_err, 1'b0);
        chk("run_acineg", acineg, !ack);
        chk("run_wcineg", wcineg, !ack);
        if (ack) begin
          chk("beat_addr", m_ac, exp_a);
          beats++;
          idle_run = 0;
          if (beats == n) begin
            fin = 1;
            normal = 1;
          end
        end else begin
          idle_run++;
        end
      end
    end
    chk("run_bound", fin, 1'b1);

    @(negedge clk);
    abort = 1'b0; mem_ack = 1'b0; force_done = 1'b0;
    if (normal) begin
      drive_busy_inputs(poke);
      #1;
      chk("finish_instr", instr, 3'b001);
      chk("finish_memreq", mem_req, 1'b0);
      chk("finish_done", xfer_done, 1'b1);
      chk("finish_err", xfer_err, 1'b0);
      chk("finish_acineg", acineg, 1'b1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;
    chk("end_ready", req_ready, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_pulse", {xfer_done, xfer_err}, 2'b00);
    chk("step_count", steps, beats);
    chk("wc_left", m_wc, n - beats);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h99; req_count = 8'd1; req_mode = 2'b00; req_down = 1'b0;
    mem_ack = 1'b0; abort = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("prerst_memreq", mem_req, 1'b1);
    rstneg = 1'b0;
    #1;
    chk_reset_vals("midrun_rst");
    @(negedge clk);
    rstneg = 1'b1;
    #1;
    chk_reset_vals("midrun_rel");
  endtask

  initial begin
    rstneg = 1'b0; req_valid = 1'b0; req_addr = '0; req_count = '0; req_mode = '0;
    req_down = 1'b0; abort = 1'b0; mem_ack = 1'b0; force_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rstneg = 1'b1;
    #1;
    chk_reset_vals("release");

    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("idle_abort_err", xfer_err, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("idle_abort_ready", req_ready, 1'b1);

    do_xfer(8'h10, 8'd3, 1'b0, 2'b00, 0, -1, -1, 1'b0, 1'b0);
    do_xfer(8'h40, 8'd2, 1'b0, 2'b01, 2, -1, -1, 1'b0, 1'b0);
    do_xfer(8'h05, 8'd4, 1'b1, 2'b10, 0, -1, -1, 1'b0, 1'b0);
    do_xfer(8'h80, 8'd5, 1'b0, 2'b00, 0, 2, -1, 1'b0, 1'b0);
    do_xfer(8'h33, 8'd1, 1'b0, 2'b00, 0, -1, -1, 1'b1, 1'b0);
    reset_mid_run();
    do_xfer(8'hF0, 8'd0, 1'b0, 2'b11, -1, -1, -1, 1'b0, 1'b1);
    do_xfer(8'h20, 8'd6, 1'b1, 2'b01, 0, -1, 2, 1'b0, 1'b0);
    do_xfer(8'h02, 8'd4, 1'b1, 2'b00, 1, -1, -1, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      do_xfer(8'($urandom), 8'($urandom_range(1, 40)), 1'($urandom), 2'($urandom),
              -1, -1, -1, 1'b0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
